syn_accumulator: RTL

SYN_ACCUMULATOR -- requirements
Module: syn_accumulator

---
 rtl/snn_pkg.sv | 15 +
 rtl/syn_accumulator_if.sv | 14 +
 rtl/syn_accumulator.sv | 100 ++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared fixed-point widths, Q-format type and accumulator FSM states
package snn_pkg;
  localparam int DW     = 16;
  localparam int INT_DW = 8;
  localparam int W      = DW + INT_DW;

  typedef logic signed [W-1:0] q_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_t;
endpackage

// File: rtl/syn_accumulator_if.sv
// rtl/syn_accumulator_if.sv - weight memory read port between accumulator and external weight store
interface syn_accumulator_if #(
  parameter int N_IN = 784,
  parameter int W    = 24
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                w_rd_en;
  logic [AW-1:0]       w_addr;
  logic signed [W-1:0] w_data;

  modport master (output w_rd_en, output w_addr, input w_data);
  modport slave  (input w_rd_en, input w_addr, output w_data);
endinterface

// File: rtl/syn_accumulator.sv
// rtl/syn_accumulator.sv - synaptic current accumulator over one spike time step
// Build option SYN_ACC_SAT_EN clamps the final sum to the W-bit range instead of wrapping.
module syn_accumulator #(
  parameter int N_IN   = 784,
  parameter int DW     = snn_pkg::DW,
  parameter int INT_DW = snn_pkg::INT_DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_IN-1:0]             in_spikes,
  syn_accumulator_if.master           wmem,
  output logic                        busy,
  output logic                        out_valid,
  output logic signed [DW+INT_DW-1:0] spiking_value
);
  localparam int W     = DW + INT_DW;
  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = W + AW;

  import snn_pkg::*;

  acc_state_t              state;
  logic [N_IN-1:0]         snap;
  logic [AW-1:0]           idx;
  logic                    rd_d;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic signed [W-1:0]     result;

  // rd_d marks the cycle in which w_data answers the read issued one cycle earlier
  always_comb begin
    addend = rd_d ? {{AW{wmem.w_data[W-1]}}, wmem.w_data} : '0;
    sum    = acc + addend;
`ifdef SYN_ACC_SAT_EN
    if ((&sum[ACC_W-1:W-1]) || ~(|sum[ACC_W-1:W-1])) begin
      result = sum[W-1:0];
    end else begin
      result = sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
    result = sum[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      snap          <= '0;
      idx           <= '0;
      rd_d          <= 1'b0;
      acc           <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      wmem.w_rd_en  <= 1'b0;
      wmem.w_addr   <= '0;
      spiking_value <= '0;
    end else begin
      out_valid    <= 1'b0;
      wmem.w_rd_en <= 1'b0;
      rd_d         <= wmem.w_rd_en;
      case (state)
        IDLE: begin
          // busy stays up through the out_valid cycle, so a start there is ignored
          if (out_valid) begin
            busy <= 1'b0;
          end else if (start && !busy) begin
            snap  <= in_spikes;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          wmem.w_addr  <= idx;
          wmem.w_rd_en <= snap[idx];
          acc          <= sum;
          if (idx == AW'(N_IN - 1)) begin
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          acc   <= sum;
          state <= DONE;
        end
        DONE: begin
          acc           <= sum;
          spiking_value <= result;
          out_valid     <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
